if_id_buf: RTL and testbench

IF_ID_BUF -- requirements
Module: if_id_buf

---
 rtl/if_id_buf_pkg.sv | 32 +++
 rtl/if_id_buf_fetch_fifo2.sv | 63 ++++++
 rtl/if_id_buf.sv | 105 ++++++++++
 tb/tb_if_id_buf.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/if_id_buf_pkg.sv
// if_id_buf_pkg -- shared widths, constants and types for the IF/ID buffer.
//   INST_ADDR_W / INST_W : instruction address and instruction word widths
//   NOP_ENC              : default bubble encoding
//   STOP / NOSTOP        : stall vector bit values
//   STALL_IF / STALL_ID  : positions of the IF and ID bits in the stall vector
//   qstate_e             : FIFO occupancy, encoded as the entry count
//   fetch_t              : one buffered {pc, inst} pair
package if_id_buf_pkg;

    localparam int INST_ADDR_W = 16;
    localparam int INST_W      = 16;

    localparam logic [INST_W-1:0] NOP_ENC = 16'h0000;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam int STALL_IF = 1;
    localparam int STALL_ID = 2;

    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } qstate_e;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fetch_t;

endpackage

// File: rtl/if_id_buf_fetch_fifo2.sv
// fetch_fifo2 -- two-entry FIFO of fetched {pc, inst} pairs.
//   clk, rst   : clock, synchronous active-high reset
//   flush_i    : empties the queue; wins over push/pop
//   push_i     : write wdata_i (ignored when full unless a pop happens too)
//   pop_i      : drop the head (ignored when empty)
//   wdata_i    : pair to enqueue
//   head_o     : oldest entry (valid when count_o != Q_EMPTY)
//   count_o    : current occupancy
module fetch_fifo2
    import if_id_buf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    flush_i,
    input  logic    push_i,
    input  logic    pop_i,
    input  fetch_t  wdata_i,
    output fetch_t  head_o,
    output qstate_e count_o
);

    fetch_t  mem_q [DEPTH];
    logic    wr_ptr_q;
    logic    rd_ptr_q;
    qstate_e count_q, count_d;
    logic    push_ok, pop_ok;

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign pop_ok  = pop_i && (count_q != Q_EMPTY);
    assign push_ok = push_i && ((count_q != Q_FULL) || pop_ok);

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10: count_d = (count_q == Q_EMPTY) ? Q_ONE : Q_FULL;
            2'b01: count_d = (count_q == Q_FULL)  ? Q_ONE : Q_EMPTY;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            count_q  <= Q_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push_ok) wr_ptr_q <= ~wr_ptr_q;
            if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i && push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_id_buf.sv
// if_id_buf -- IF/ID pipeline register with a 2-entry skid queue.
//   clk, rst   : clock, synchronous active-high reset (beats flush)
//   if_pc      : PC of this cycle's fetch
//   if_inst    : fetched instruction word
//   if_valid   : if_pc/if_inst carry a real fetch
//   flush      : discard queued and same-cycle fetches, bubble to decode
//   stall      : stall vector; bit 2 stalls decode
//   id_pc      : registered PC to decode
//   id_inst    : registered instruction to decode
//   id_valid   : id_pc/id_inst are a real instruction
//   fetch_hold : combinational; PC stage must hold its PC
module if_id_buf
    import if_id_buf_pkg::*;
#(
    parameter logic [INST_W-1:0] NOP_INST = NOP_ENC,
    parameter int                DEPTH    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INST_ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0]      if_inst,
    input  logic                   if_valid,
    input  logic                   flush,
    input  logic [5:0]             stall,
    output logic [INST_ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0]      id_inst,
    output logic                   id_valid,
    output logic                   fetch_hold
);

    logic                   id_ready;
    logic                   bypass;
    logic                   push, pop;
    fetch_t                 head;
    qstate_e                count;
    logic [INST_ADDR_W-1:0] id_pc_q,  id_pc_d;
    logic [INST_W-1:0]      id_inst_q, id_inst_d;
    logic                   id_valid_q, id_valid_d;

    // Only the ID bit matters here; an IF-only stall simply starves the queue.
    logic unused_stall;
    assign unused_stall = ^{stall[5:3], stall[STALL_IF], stall[0]};

    assign id_ready = (stall[STALL_ID] == NOSTOP);
    assign pop      = id_ready && (count != Q_EMPTY);
    // Empty queue and a ready decoder: the fetch goes straight to the register.
    assign bypass   = id_ready && (count == Q_EMPTY) && if_valid;
    assign push     = if_valid && !bypass;

    assign fetch_hold = (count == Q_FULL) ||
                        ((count == Q_ONE) && !id_ready && if_valid);

    fetch_fifo2 #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ('{pc: if_pc, inst: if_inst}),
        .head_o  (head),
        .count_o (count)
    );

    always_comb begin
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        if (flush) begin
            id_pc_d    = '0;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
        end else if (id_ready) begin
            if (count != Q_EMPTY) begin
                id_pc_d    = head.pc;
                id_inst_d  = head.inst;
                id_valid_d = 1'b1;
            end else if (if_valid) begin
                id_pc_d    = if_pc;
                id_inst_d  = if_inst;
                id_valid_d = 1'b1;
            end else begin
                id_pc_d    = '0;
                id_inst_d  = NOP_INST;
                id_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc_q    <= '0;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
        end else begin
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;
    assign id_valid = id_valid_q;

endmodule

// File: tb/tb_if_id_buf.sv
module tb_if_id_buf;
    import if_id_buf_pkg::*;

    logic        clk = 1'b0;
    logic        rst, if_valid, flush;
    logic [15:0] if_pc, if_inst;
    logic [5:0]  stall;
    logic [15:0] id_pc, id_inst;
    logic        id_valid, fetch_hold;

    int checks = 0;
    int errors = 0;

    if_id_buf dut (
        .clk        (clk),
        .rst        (rst),
        .if_pc      (if_pc),
        .if_inst    (if_inst),
        .if_valid   (if_valid),
        .flush      (flush),
        .stall      (stall),
        .id_pc      (id_pc),
        .id_inst    (id_inst),
        .id_valid   (id_valid),
        .fetch_hold (fetch_hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, vld, flush;
        logic [5:0]  stall;
        logic [15:0] pc, inst;
        logic        chk_hold, e_hold;
        logic [15:0] e_pc, e_inst;
        logic        e_vld;
    } vec_t;

    vec_t tbl[$];

    localparam logic [5:0] S0 = 6'b000000;
    localparam logic [5:0] S1 = 6'b000010;
    localparam logic [5:0] S2 = 6'b000100;

    task automatic v(input logic r, input logic vl, input logic fl, input logic [5:0] st,
                     input logic [15:0] pc, input logic [15:0] inst, input logic ch,
                     input logic eh, input logic [15:0] epc, input logic [15:0] ei,
                     input logic ev);
        vec_t x;
        x.rst = r; x.vld = vl; x.flush = fl; x.stall = st; x.pc = pc; x.inst = inst;
        x.chk_hold = ch; x.e_hold = eh; x.e_pc = epc; x.e_inst = ei; x.e_vld = ev;
        tbl.push_back(x);
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic vl, input logic fl,
                         input logic [5:0] st, input logic [15:0] pc, input logic [15:0] inst);
        rst = r; if_valid = vl; flush = fl; stall = st; if_pc = pc; if_inst = inst;
    endtask

    // Reference model: a plain queue plus the decode register contents.
    fetch_t      mq[$];
    logic [15:0] m_pc, m_inst;
    logic        m_vld;

    task automatic model_step(input logic r, input logic vl, input logic fl,
                              input logic [5:0] st, input logic [15:0] pc,
                              input logic [15:0] inst);
        fetch_t w;
        w.pc = pc; w.inst = inst;
        if (r) begin
            mq.delete(); m_pc = 0; m_inst = NOP_ENC; m_vld = 0;
        end else if (fl) begin
            mq.delete(); m_pc = 0; m_inst = NOP_ENC; m_vld = 0;
        end else if (!st[2]) begin
            if (mq.size() > 0) begin
                fetch_t h;
                h = mq.pop_front();
                m_pc = h.pc; m_inst = h.inst; m_vld = 1;
                if (vl) mq.push_back(w);
            end else if (vl) begin
                m_pc = pc; m_inst = inst; m_vld = 1;
            end else begin
                m_pc = 0; m_inst = NOP_ENC; m_vld = 0;
            end
        end else if (vl && mq.size() < 2) begin
            mq.push_back(w);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, S0, 16'h0, 16'h0);

        //  rst vld fl  stall pc       inst     ch eh  e_pc     e_inst   e_vld
        v(1, 0, 0, S0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0); // reset
        v(0, 1, 0, S0, 16'h0000, 16'h1234, 1, 0, 16'h0000, 16'h1234, 1); // bypass
        v(0, 1, 0, S2, 16'h0002, 16'h2222, 1, 0, 16'h0000, 16'h1234, 1); // stall, push
        v(0, 1, 0, S2, 16'h0004, 16'h4444, 1, 1, 16'h0000, 16'h1234, 1); // ONE+stall -> hold
        v(0, 0, 0, S2, 16'h0000, 16'h0000, 1, 1, 16'h0000, 16'h1234, 1); // FULL
        v(0, 0, 0, S0, 16'h0000, 16'h0000, 1, 1, 16'h0002, 16'h2222, 1); // drain 1
        v(0, 0, 0, S0, 16'h0000, 16'h0000, 1, 0, 16'h0004, 16'h4444, 1); // drain 2
        v(0, 0, 0, S0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0); // bubble
        v(0, 1, 0, S2, 16'h000A, 16'hAAAA, 1, 0, 16'h0000, 16'h0000, 0);
        v(0, 1, 0, S2, 16'h000C, 16'hCCCC, 1, 1, 16'h0000, 16'h0000, 0);
        v(0, 1, 0, S0, 16'h0008, 16'h8888, 1, 1, 16'h000A, 16'hAAAA, 1); // pop+push at FULL
        v(0, 0, 0, S2, 16'h0000, 16'h0000, 1, 1, 16'h000A, 16'hAAAA, 1); // still FULL
        v(0, 1, 1, S2, 16'h0006, 16'h6666, 1, 1, 16'h0000, 16'h0000, 0); // flush at FULL
        v(0, 0, 0, S0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0);
        v(0, 0, 0, S0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0);
        v(0, 0, 0, S1, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0); // IF stall, empty
        v(0, 0, 0, S1, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0);
        v(0, 1, 0, S2, 16'h0010, 16'h1010, 1, 0, 16'h0000, 16'h0000, 0);
        v(0, 1, 0, S2, 16'h0012, 16'h1212, 1, 1, 16'h0000, 16'h0000, 0);
        v(1, 1, 1, S2, 16'h0014, 16'h1414, 1, 1, 16'h0000, 16'h0000, 0); // rst at FULL
        v(0, 0, 0, S0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0); // nothing stale
        v(0, 0, 0, S0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0);
        v(0, 1, 1, S0, 16'h0020, 16'h2020, 1, 0, 16'h0000, 16'h0000, 0); // flush kills bypass
        v(0, 0, 0, S0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].flush, tbl[i].stall, tbl[i].pc, tbl[i].inst);
            #1;
            if (tbl[i].chk_hold) chk($sformatf("vec%0d fetch_hold", i), {15'b0, fetch_hold}, {15'b0, tbl[i].e_hold});
            @(posedge clk); #1;
            chk($sformatf("vec%0d id_pc", i),    id_pc,   tbl[i].e_pc);
            chk($sformatf("vec%0d id_inst", i),  id_inst, tbl[i].e_inst);
            chk($sformatf("vec%0d id_valid", i), {15'b0, id_valid}, {15'b0, tbl[i].e_vld});
        end

        // Randomized phase against the queue model.
        mq.delete(); m_pc = 0; m_inst = NOP_ENC; m_vld = 0;
        for (int c = 0; c < 600; c++) begin
            logic        r, vl, fl;
            logic [5:0]  st;
            logic [15:0] pc, inst;
            logic        e_hold;
            r  = (c == 0) || ($urandom_range(0, 49) == 0);
            fl = ($urandom_range(0, 11) == 0);
            vl = ($urandom_range(0, 2) != 0);
            st = 6'($urandom);
            st[2] = ($urandom_range(0, 2) == 0);
            pc = 16'($urandom); inst = 16'($urandom);
            drive(r, vl, fl, st, pc, inst);
            #1;
            e_hold = (mq.size() == 2) || (mq.size() == 1 && st[2] && vl);
            if (c > 0) chk($sformatf("rnd%0d fetch_hold", c), {15'b0, fetch_hold}, {15'b0, e_hold});
            model_step(r, vl, fl, st, pc, inst);
            @(posedge clk); #1;
            chk($sformatf("rnd%0d id_pc", c),    id_pc,   m_pc);
            chk($sformatf("rnd%0d id_inst", c),  id_inst, m_inst);
            chk($sformatf("rnd%0d id_valid", c), {15'b0, id_valid}, {15'b0, m_vld});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
